instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  RV32I fetch stage directly upstream of the decode/register-file stage (control_reg).
//  - Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
//  - Holds the returned word in an instruction register until decode consumes it.
//  - Applies PC redirects signalled by load_pc from decode.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset; must be word aligned
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  stall        in   1   1 = decode not ready; hold current instruction
//  load_pc      in   1   redirect request from decode, qualified by instr_valid
//  pc_target    in   32  redirect target (branch/jump address)
//  imem_req     out  1   read request to instruction memory
//  imem_addr    out  32  word address of request (= pc)
//  imem_ack     in   1   read data valid this cycle
//  imem_rdata   in   32  instruction word from memory
//  instruction  out  32  held instruction to decode
//  instr_valid  out  1   instruction/pc are valid for decode
//  pc           out  32  address of held/pending instruction
//  pc_plus4     out  32  pc + 4, for JAL/JALR link value
//  fetch_count  out  32  number of instructions handed to decode
// BEHAVIOUR
//  - Reset (rst=0, async): state=FETCH, pc=RESET_PC, instruction=32'h0000_0013 (NOP),
//    instr_valid=0, fetch_count=0. imem_req deasserts immediately.
//  - FSM states:
//    - FETCH: imem_req=1, imem_addr=pc; req held until ack.
//      On posedge with imem_ack=1: instruction<=imem_rdata, go VALID.
//      Minimum latency: req to instr_valid is 1 cycle (zero-wait memory).
//    - VALID: instr_valid=1, imem_req=0.
//      If stall=1: hold everything; load_pc is ignored.
//      If stall=0 (advance): pc<=load_pc ? {pc_target[31:2],2'b00} : pc+4;
//      fetch_count+=1; go FETCH.
//      instruction keeps its last value; instr_valid=0 in FETCH.
//  - Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); fetch_count wraps likewise.
//  - imem_ack outside FETCH is ignored. No abort of an outstanding request except reset.
//    After reset the first req is issued at RESET_PC.
//  - load_pc and stall together: stall wins; the redirect must be re-presented when stall drops.
//  - imem_addr is combinational from pc. All other outputs are registered.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    - A redirect with pc_target[1:0]!=0 enters state FAULT instead of FETCH.
//    - FAULT: imem_req=0, instr_valid=0, pc=unaligned target, output fetch_fault=1.
//    - FAULT is left only by reset. Port fetch_fault (out, 1) exists only in this build.
//  MISALIGN_TRAP_EN undefined:
//    - Low two target bits are silently forced to 0. There is no FAULT state and no fetch_fault port.
// STRUCTURE
//  - Package rv32i_pkg holds:
//    - typedef enum logic [1:0] fetch_state_t {FETCH, VALID, FAULT}
//    - localparam RV_NOP = 32'h0000_0013
//    - localparam XLEN = 32
//  - Single module, no sub-modules; pc/next-pc logic is inline.
// TESTING
//  - Reset, zero-wait memory (ack same cycle as req):
//    -> imem_addr=0x0, instr_valid=1 one cycle later, then 0x4, 0x8 on successive advances.
//  - Memory returns ack after 3 wait cycles:
//    -> imem_req held high for 4 cycles; imem_addr constant; instruction = rdata when instr_valid rises.
//  - VALID with stall=1 for 5 cycles:
//    -> pc, instruction, instr_valid, fetch_count unchanged.
//    -> On release, fetch_count increments by exactly 1.
//  - Redirect: load_pc=1, pc_target=0x0000_0100, stall=0 -> next imem_addr=0x100.
//    Same redirect with stall=1 -> ignored.
//  - Wrap: RESET_PC=32'hFFFF_FFFC, one advance -> pc=0x0000_0000, pc_plus4=0x4.
//  - rst pulsed low mid-FETCH with ack pending:
//    -> instr_valid=0, pc=RESET_PC, instruction=NOP. A late ack during reset is ignored.
//  - (MISALIGN_TRAP_EN) redirect to 0x102 -> fetch_fault=1, imem_req stays 0 until reset.
//    Without the macro -> imem_addr=0x100.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I types and constants for the fetch stage
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction memory req/ack read port
interface instruction_fetch_if;
    import rv32i_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV32I fetch stage: PC, imem handshake, instruction register
// MISALIGN_TRAP_EN: misaligned redirects park the stage in FAULT and expose fetch_fault.
module instruction_fetch
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    instruction_fetch_if.master imem,
    input  logic              stall,
    input  logic              load_pc,
    input  logic [XLEN-1:0]   pc_target,
    output logic [XLEN-1:0]   instruction,
    output logic              instr_valid,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic [XLEN-1:0]   fetch_count
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              fetch_fault
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] count_q, count_d;
    logic            valid_q, valid_d;
    logic            req;
    logic [XLEN-1:0] redirect_pc;

    assign redirect_pc = {pc_target[XLEN-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    assign fetch_fault = fault_q;
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^pc_target[1:0];
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        count_d    = count_q;
        req        = 1'b0;
        case (state_q)
            FETCH: begin
                req = 1'b1;
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                // A stalled decode also masks load_pc; decode re-presents it later.
                if (!stall) begin
                    count_d = count_q + 1'b1;
                    state_d = FETCH;
                    pc_d    = load_pc ? redirect_pc : pc_plus4_q;
`ifdef MISALIGN_TRAP_EN
                    if (load_pc && (pc_target[1:0] != 2'b00)) begin
                        pc_d    = pc_target;
                        state_d = FAULT;
                    end
`endif
                    pc_plus4_d = pc_d + 32'd4;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: state_d = FETCH;
        endcase
        valid_d = (state_d == VALID);
`ifdef MISALIGN_TRAP_EN
        fault_d = (state_d == FAULT);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + 32'd4;
            instr_q    <= RV_NOP;
            count_q    <= '0;
            valid_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
`ifdef MISALIGN_TRAP_EN
            fault_q    <= fault_d;
`endif
        end
    end

    // Request is gated by reset so it drops the instant reset asserts.
    assign imem.imem_req  = req & rst;
    assign imem.imem_addr = pc_q;

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch (MISALIGN_TRAP_EN aware)
module tb_instruction_fetch;
    import rv32i_pkg::*;

    logic clk;
    logic rst;
    logic stall, load_pc;
    logic [31:0] pc_target;
    logic [31:0] instruction, pc, pc_plus4, fetch_count;
    logic instr_valid;
    logic stall1, load_pc1;
    logic [31:0] pc_target1;
    logic [31:0] instruction1, pc1, pc_plus4_1, fetch_count1;
    logic instr_valid1;
`ifdef MISALIGN_TRAP_EN
    logic fetch_fault, fetch_fault1;
`endif

    instruction_fetch_if if0();
    instruction_fetch_if if1();

    instruction_fetch dut (
        .clk(clk), .rst(rst), .imem(if0.master),
        .stall(stall), .load_pc(load_pc), .pc_target(pc_target),
        .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
        .pc_plus4(pc_plus4), .fetch_count(fetch_count)
`ifdef MISALIGN_TRAP_EN
        , .fetch_fault(fetch_fault)
`endif
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem(if1.master),
        .stall(stall1), .load_pc(load_pc1), .pc_target(pc_target1),
        .instruction(instruction1), .instr_valid(instr_valid1), .pc(pc1),
        .pc_plus4(pc_plus4_1), .fetch_count(fetch_count1)
`ifdef MISALIGN_TRAP_EN
        , .fetch_fault(fetch_fault1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return addr ^ 32'h1357_9BDF;
    endfunction

    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    int          wait_n;
    bit          mem_en;
    logic [31:0] sb_pc[$];
    logic [31:0] sb_ins[$];

    // Memory model: acks after wait_n stall cycles and queues the expected result.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (if0.imem_req) begin
                    check_eq("imem_addr", if0.imem_addr, exp_pc);
                    if (cnt == wait_n) begin
                        if0.imem_ack   = 1'b1;
                        if0.imem_rdata = mem_data(exp_pc);
                        sb_pc.push_back(exp_pc);
                        sb_ins.push_back(mem_data(exp_pc));
                        cnt = 0;
                    end else begin
                        if0.imem_ack = 1'b0;
                        cnt++;
                    end
                end else begin
                    if0.imem_ack = 1'b0;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: each rising instr_valid consumes one scoreboard entry.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (instr_valid && !prev) begin
                if (sb_pc.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check_eq("sb_pc", pc, sb_pc.pop_front());
                    check_eq("sb_instruction", instruction, sb_ins.pop_front());
                end
            end
            prev = instr_valid;
        end
    end

    task automatic wait_valid(input int exp_lat);
        int cycles;
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!instr_valid && cycles < 50);
        check_eq("latency", cycles, exp_lat);
    endtask

    task automatic advance(input bit redirect, input logic [31:0] tgt);
        @(posedge clk); #1;
        load_pc   = redirect;
        pc_target = tgt;
        stall     = 1'b0;
        @(posedge clk); #1;
        stall     = 1'b1;
        load_pc   = 1'b0;
        exp_count = exp_count + 1;
        exp_pc    = redirect ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b1; load_pc = 1'b0; pc_target = '0;
        stall1 = 1'b1; load_pc1 = 1'b0; pc_target1 = '0;
        if0.imem_ack = 1'b0; if0.imem_rdata = '0;
        if1.imem_ack = 1'b1; if1.imem_rdata = 32'hCAFE_0001;
        mem_en = 1'b1; wait_n = 0; exp_pc = 32'h0; exp_count = 0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", instr_valid, 1'b0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_instr", instruction, RV_NOP);
        check_eq("rst_count", fetch_count, 32'h0);
        check_eq("rst_req", if0.imem_req, 1'b0);
        check_eq("rst_pc_plus4", pc_plus4, 32'h4);
        rst = 1'b1;

        // Zero-wait memory: 0x0, 0x4, 0x8.
        wait_valid(1);
        check_eq("count0", fetch_count, 32'd0);
        advance(1'b0, '0);
        wait_valid(1);
        advance(1'b0, '0);
        wait_valid(1);
        check_eq("pc_plus4_8", pc_plus4, 32'hC);
        check_eq("count2", fetch_count, exp_count);

        // Three wait states.
        wait_n = 3;
        advance(1'b0, '0);
        wait_valid(4);
        check_eq("ws_instr", instruction, mem_data(32'hC));

        // Stall five cycles with a masked redirect.
        load_pc = 1'b1; pc_target = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("stall_pc", pc, exp_pc);
            check_eq("stall_instr", instruction, mem_data(exp_pc));
            check_eq("stall_valid", instr_valid, 1'b1);
            check_eq("stall_count", fetch_count, exp_count);
        end
        load_pc = 1'b0;
        wait_n = 0;
        advance(1'b0, '0);
        check_eq("stall_release_count", fetch_count, exp_count);
        wait_valid(1);

        // Redirect.
        advance(1'b1, 32'h0000_0100);
        check_eq("redirect_addr", if0.imem_addr, 32'h100);
        wait_valid(1);

        // Reset while a request waits, with a stray ack during reset.
        wait_n = 3;
        advance(1'b0, '0);
        @(posedge clk); #1;
        mem_en = 1'b0;
        if0.imem_ack = 1'b1; if0.imem_rdata = 32'hDEAD_BEEF;
        rst = 1'b0;
        #1;
        check_eq("midrst_req", if0.imem_req, 1'b0);
        check_eq("midrst_valid", instr_valid, 1'b0);
        check_eq("midrst_pc", pc, 32'h0);
        check_eq("midrst_instr", instruction, RV_NOP);
        repeat (2) @(posedge clk);
        #1;
        check_eq("late_ack_valid", instr_valid, 1'b0);
        check_eq("late_ack_instr", instruction, RV_NOP);
        check_eq("late_ack_count", fetch_count, 32'h0);
        if0.imem_ack = 1'b0;
        exp_pc = 32'h0; exp_count = 0; wait_n = 0;
        mem_en = 1'b1;
        rst = 1'b1;
        wait_valid(1);

        // Misaligned redirect.
`ifdef MISALIGN_TRAP_EN
        advance(1'b1, 32'h0000_0102);
        check_eq("fault_flag", fetch_fault, 1'b1);
        check_eq("fault_pc", pc, 32'h102);
        check_eq("fault_valid", instr_valid, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("fault_req", if0.imem_req, 1'b0);
        end
`else
        advance(1'b1, 32'h0000_0102);
        check_eq("misalign_addr", if0.imem_addr, 32'h100);
        wait_valid(1);
`endif

        // Wrap instance: sits in VALID at 0xFFFF_FFFC.
        check_eq("wrap_pc0", pc1, 32'hFFFF_FFFC);
        check_eq("wrap_plus4_0", pc_plus4_1, 32'h0);
        check_eq("wrap_valid0", instr_valid1, 1'b1);
        @(posedge clk); #1;
        stall1 = 1'b0;
        @(posedge clk); #1;
        stall1 = 1'b1;
        @(posedge clk); #1;
        check_eq("wrap_pc", pc1, 32'h0);
        check_eq("wrap_plus4", pc_plus4_1, 32'h4);
        check_eq("wrap_count", fetch_count1, 32'd1);
        check_eq("wrap_valid", instr_valid1, 1'b1);

        check_eq("sb_drained", sb_pc.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
